// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] DIR_SHORT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DN    = 2'b10;

  // Direction policy: 2'b11 behaves like DIR_SHORT.
  function automatic logic pick_up(input logic [1:0] dir, input logic short_up);
    unique case (dir)
      DIR_UP:  pick_up = 1'b1;
      DIR_DN:  pick_up = 1'b0;
      default: pick_up = short_up;
    endcase
  endfunction

endpackage

// File: rtl/updown_cnt_core.sv
// Wrapping up/down binary counter; advances one step per cycle while en is high.
module updown_cnt_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             updown,
  output logic [WIDTH-1:0] bin_count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= updown ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  assign bin_count = count_q;

endmodule

// File: rtl/updown_seq_ctrl.sv
// Command sequencer that steps the up/down counter to a target value.
// Define UPDOWN_SEQ_ABORT_EN to add the abort/aborted ports.
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [1:0]       cmd_dir,
  output logic             updown,
  output logic             cnt_step,
  output logic [WIDTH-1:0] bin_count,
  output logic             busy,
  output logic             done
`ifdef UPDOWN_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam int unsigned PW = $clog2(STEP_DIV + 1);
  localparam logic [PW-1:0] PresLast = PW'(STEP_DIV - 1);

  state_e           state_q;
  logic [PW-1:0]    presc_q;
  logic [WIDTH-1:0] target_q;
  logic             updown_q;

  logic             at_target;
  logic             short_up;
  logic             abort_hit;
  logic [WIDTH-1:0] dist_up;
  logic [WIDTH-1:0] dist_dn;

  // Modular distances both ways; ties resolve upward.
  assign dist_up   = cmd_target - bin_count;
  assign dist_dn   = bin_count - cmd_target;
  assign short_up  = (dist_up <= dist_dn);
  assign at_target = (bin_count == target_q);

`ifdef UPDOWN_SEQ_ABORT_EN
  logic aborted_q;
  assign abort_hit = abort && (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end

  assign aborted = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      target_q <= '0;
      updown_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q  <= S_RUN;
            target_q <= cmd_target;
            updown_q <= pick_up(cmd_dir, short_up);
            presc_q  <= '0;
          end
        end
        S_RUN: begin
          if (abort_hit) begin
            state_q <= S_IDLE;
          end else if (at_target) begin
            state_q <= S_DONE;
          end else if (presc_q == PresLast) begin
            presc_q <= '0;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cnt_step  = (state_q == S_RUN) && !at_target && (presc_q == PresLast) && !abort_hit;
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign updown    = updown_q;

  updown_cnt_core #(
    .WIDTH(WIDTH)
  ) u_cnt_core (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_step),
    .updown   (updown_q),
    .bin_count(bin_count)
  );

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl: vector table, randomized commands vs. a distance model,
// and hand-written multi-cycle sequences (optional abort under UPDOWN_SEQ_ABORT_EN).
module tb_updown_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_target;
  logic [1:0] cmd_dir;
  logic       updown, cnt_step, busy, done;
  logic [2:0] bin_count;

  logic       b_valid, b_ready;
  logic [2:0] b_target;
  logic [1:0] b_dir;
  logic       b_updown, b_step, b_busy, b_done;
  logic [2:0] b_count;

`ifdef UPDOWN_SEQ_ABORT_EN
  logic abort, aborted, b_abort, b_aborted;
`endif

  always #5 clk = ~clk;

  updown_seq_ctrl #(.WIDTH(3), .STEP_DIV(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_dir(cmd_dir), .updown(updown), .cnt_step(cnt_step),
    .bin_count(bin_count), .busy(busy), .done(done)
`ifdef UPDOWN_SEQ_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  updown_seq_ctrl #(.WIDTH(3), .STEP_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_target(b_target), .cmd_dir(b_dir), .updown(b_updown), .cnt_step(b_step),
    .bin_count(b_count), .busy(b_busy), .done(b_done)
`ifdef UPDOWN_SEQ_ABORT_EN
    , .abort(b_abort), .aborted(b_aborted)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int t;
    int dir;
    bit up;
    int k;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap8(input int v);
    return ((v % 8) + 8) % 8;
  endfunction

  // Reference: walk the ring in each direction and count hops to the target.
  task automatic plan(input int c, input int t, input int dir, output bit up, output int k);
    int du = 0;
    int dd = 0;
    int x;
    x = c;
    while (x != t) begin x = wrap8(x + 1); du++; end
    x = c;
    while (x != t) begin x = wrap8(x - 1); dd++; end
    if (dir == 1)      up = 1'b1;
    else if (dir == 2) up = 1'b0;
    else               up = (du <= dd);
    k = up ? du : dd;
  endtask

  // Issue one command on the STEP_DIV=1 instance and check every cycle until idle again.
  task automatic run_cmd(input string tag, input int start, input int t, input int dir,
                         input bit up, input int k);
    logic [7:0] exp_v, act_v;
    int m;
    cmd_target = 3'(t);
    cmd_dir    = 2'(dir);
    cmd_valid  = 1'b1;
    chk({tag, "/ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int j = 0; j <= k + 1; j++) begin
      m = (j < k) ? j : k;
      exp_v = {3'(wrap8(start + (up ? m : -m))), (j < k), (j == k + 1), 1'b1, up, 1'b0};
      act_v = {bin_count, cnt_step, done, busy, updown, cmd_ready};
      chk($sformatf("%s/cyc%0d{cnt,step,done,busy,ud,rdy}", tag, j), 32'(act_v), 32'(exp_v));
      tick();
    end
    chk({tag, "/idle{cnt,busy,rdy,done}"}, 32'({bin_count, busy, cmd_ready, done}),
        32'({3'(t), 1'b0, 1'b1, 1'b0}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cur, t, d, k, c, steps, tgt_a;
    bit up, seen;

    tbl[0] = '{5, 1, 1'b1, 5};
    tbl[1] = '{1, 0, 1'b1, 4};
    tbl[2] = '{5, 0, 1'b1, 4};
    tbl[3] = '{3, 0, 1'b0, 2};
    tbl[4] = '{3, 0, 1'b1, 0};
    tbl[5] = '{6, 2, 1'b0, 5};
    tbl[6] = '{2, 3, 1'b1, 4};
    tbl[7] = '{0, 1, 1'b1, 6};
    tbl[8] = '{7, 0, 1'b0, 1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_dir = '0;
    b_valid = 1'b0; b_target = '0; b_dir = '0;
`ifdef UPDOWN_SEQ_ABORT_EN
    abort = 1'b0; b_abort = 1'b0;
`endif

    // Reset held two cycles.
    tick(); tick();
    chk("reset{cnt,busy,done,ud,rdy}", 32'({bin_count, busy, done, updown, cmd_ready}),
        32'({3'd0, 1'b0, 1'b0, 1'b1, 1'b0}));
    reset = 1'b0;
    tick();
    chk("post_reset/ready", 32'(cmd_ready), 32'd1);
    chk("post_reset/cnt_step", 32'(cnt_step), 32'd0);

    // Vector table, chained from count 0.
    cur = 0;
    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("tbl%0d", i), cur, tbl[i].t, tbl[i].dir, tbl[i].up, tbl[i].k);
      cur = tbl[i].t;
    end

    // Randomized commands against the distance model.
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 3));
      plan(cur, t, d, up, k);
      run_cmd($sformatf("rnd%0d", i), cur, t, d, up, k);
      cur = t;
    end

    // cmd_valid held high through RUN: ignored until idle, then accepted.
    tgt_a = wrap8(cur + 2);
    cmd_target = 3'(tgt_a); cmd_dir = 2'd1; cmd_valid = 1'b1;
    tick();
    cmd_target = 3'(wrap8(tgt_a + 3)); cmd_dir = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        chk("hold/ready_low", 32'(cmd_ready), 32'd0);
        tick();
      end
    end
    chk("hold/done_seen", 32'(seen), 32'd1);
    chk("hold/cnt_at_done", 32'(bin_count), 32'(tgt_a));
    tick();
    chk("hold/ready_after_done", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("hold/second_accepted", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    chk("hold/second_done", 32'({seen, bin_count}), 32'({1'b1, 3'(wrap8(tgt_a + 3))}));
    tick();

    // Reset at the second step of a 4-step run.
    cur = wrap8(tgt_a + 3);
    cmd_target = 3'(wrap8(cur + 4)); cmd_dir = 2'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_mid/second_step", 32'({bin_count, cnt_step}), 32'({3'(wrap8(cur + 1)), 1'b1}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid{cnt,busy,done,ud}", 32'({bin_count, busy, done, updown}),
        32'({3'd0, 1'b0, 1'b0, 1'b1}));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy || cnt_step) seen = 1'b1;
      tick();
    end
    chk("rst_mid/no_activity", 32'(seen), 32'd0);
    cur = 0;

    // STEP_DIV=3: two steps finish at N+8; zero steps at N+2.
    b_target = 3'd2; b_dir = 2'd1; b_valid = 1'b1;
    chk("div3/ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    c = 1; steps = 0;
    while (!b_done && c < 30) begin
      if (c == 3) chk("div3/cnt_before_step", 32'(b_count), 32'd0);
      if (c == 4) chk("div3/cnt_after_step", 32'(b_count), 32'd1);
      if (b_step) steps++;
      tick(); c++;
    end
    chk("div3/done_cycle", 32'(c), 32'd8);
    chk("div3/steps", 32'(steps), 32'd2);
    chk("div3/final_cnt", 32'(b_count), 32'd2);
    tick();
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    c = 1; steps = 0;
    while (!b_done && c < 30) begin
      if (b_step) steps++;
      tick(); c++;
    end
    chk("div3/k0_done_cycle", 32'({c[7:0], 8'(steps)}), 32'({8'd2, 8'd0}));
    tick();

`ifdef UPDOWN_SEQ_ABORT_EN
    // Abort at count 2 of a 0->6 run.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort/idle_ignored", 32'({aborted, busy}), 32'd0);
    cmd_target = 3'd6; cmd_dir = 2'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("abort/cnt_before", 32'(bin_count), 32'd2);
    abort = 1'b1;
    #1;
    chk("abort/no_step", 32'(cnt_step), 32'd0);
    tick();
    abort = 1'b0;
    chk("abort{aborted,busy,done,rdy,cnt}", 32'({aborted, busy, done, cmd_ready, bin_count}),
        32'({1'b1, 1'b0, 1'b0, 1'b1, 3'd2}));
    tick();
    chk("abort/pulse_end", 32'({aborted, bin_count}), 32'({1'b0, 3'd2}));
    run_cmd("abort/next", 2, 4, 1, 1'b1, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
